// File: rtl/i2c_pkg.sv
// Shared types and defaults for the I2C line conditioning path.
package i2c_pkg;

  localparam logic I2C_IDLE_LEVEL      = 1'b1;
  localparam int   DEFAULT_SYNC_STAGES = 2;
  localparam int   DEFAULT_FILT_W      = 4;

  // Filtered view of one bus line: level plus single-cycle edge strobes.
  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
  } i2c_line_t;

endpackage

// File: rtl/i2c_line_conditioner_if.sv
// Raw pad inputs, filter configuration and conditioned outputs of the I2C line conditioner.
interface i2c_line_conditioner_if
  import i2c_pkg::*;
#(
  parameter int FILT_W = DEFAULT_FILT_W
);
  logic              SDA_in;
  logic              SCL_in;
  logic [FILT_W-1:0] filter_len;
  logic              SDA_sync;
  logic              SCL_sync;
  logic              SDA_rise;
  logic              SDA_fall;
  logic              SCL_rise;
  logic              SCL_fall;
  logic              start_det;
  logic              stop_det;
  logic              bus_busy;

  // The master side drives the pads and configuration; the conditioner is the slave.
  modport master (
    output SDA_in, SCL_in, filter_len,
    input  SDA_sync, SCL_sync, SDA_rise, SDA_fall, SCL_rise, SCL_fall,
           start_det, stop_det, bus_busy
  );

  modport slave (
    input  SDA_in, SCL_in, filter_len,
    output SDA_sync, SCL_sync, SDA_rise, SDA_fall, SCL_rise, SCL_fall,
           start_det, stop_det, bus_busy
  );
endinterface

// File: rtl/i2c_glitch_filter.sv
// Single-line synchroniser, programmable spike filter and edge strobe generator.
module i2c_glitch_filter
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int FILT_W      = DEFAULT_FILT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_raw,
  input  logic [FILT_W-1:0] i_filter_len,
  output i2c_line_t         o_line,
  output logic              o_delayed
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_filt;
  logic                   r_dly;
  logic [FILT_W-1:0]      r_cnt;
  logic                   w_stable;

  assign w_stable = r_sync[SYNC_STAGES-1];

  // The level only follows the synchronised input once a mismatch has outlasted
  // filter_len cycles; the >= compare fires before the counter could ever wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= {SYNC_STAGES{I2C_IDLE_LEVEL}};
      r_filt <= I2C_IDLE_LEVEL;
      r_dly  <= I2C_IDLE_LEVEL;
      r_cnt  <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
      r_dly  <= r_filt;
      if (w_stable == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt >= i_filter_len) begin
        r_filt <= w_stable;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    o_line.level = r_filt;
    o_line.rise  = r_filt & ~r_dly;
    o_line.fall  = ~r_filt & r_dly;
  end

  assign o_delayed = r_dly;

endmodule

// File: rtl/i2c_line_conditioner.sv
// Conditions raw SDA/SCL pads into clean clk-domain levels and edge strobes.
// Define I2C_BUS_BUSY_EN to enable START/STOP detection and bus_busy tracking.
module i2c_line_conditioner
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int FILT_W      = DEFAULT_FILT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  i2c_line_conditioner_if.slave  bus
);

  i2c_line_t w_sda;
  i2c_line_t w_scl;
  logic      w_sdaDly;
  logic      w_sclDly;

  i2c_glitch_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_W      (FILT_W)
  ) u_sdaFilter (
    .clk          (clk),
    .rst          (rst),
    .i_raw        (bus.SDA_in),
    .i_filter_len (bus.filter_len),
    .o_line       (w_sda),
    .o_delayed    (w_sdaDly)
  );

  i2c_glitch_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_W      (FILT_W)
  ) u_sclFilter (
    .clk          (clk),
    .rst          (rst),
    .i_raw        (bus.SCL_in),
    .i_filter_len (bus.filter_len),
    .o_line       (w_scl),
    .o_delayed    (w_sclDly)
  );

  assign bus.SDA_sync = w_sda.level;
  assign bus.SCL_sync = w_scl.level;
  assign bus.SDA_rise = w_sda.rise;
  assign bus.SDA_fall = w_sda.fall;
  assign bus.SCL_rise = w_scl.rise;
  assign bus.SCL_fall = w_scl.fall;

`ifdef I2C_BUS_BUSY_EN
  logic w_start;
  logic w_stop;
  logic r_busy;
  logic w_unusedSdaDly;

  // SCL must be high both now and last cycle, so a simultaneous SDA/SCL edge is ignored.
  assign w_start        = w_sda.fall & w_scl.level & w_sclDly;
  assign w_stop         = w_sda.rise & w_scl.level & w_sclDly;
  assign w_unusedSdaDly = w_sdaDly;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
    end else if (w_start) begin
      r_busy <= 1'b1;
    end else if (w_stop) begin
      r_busy <= 1'b0;
    end
  end

  assign bus.start_det = w_start;
  assign bus.stop_det  = w_stop;
  assign bus.bus_busy  = r_busy;
`else
  logic w_unusedDly;

  assign w_unusedDly   = w_sdaDly ^ w_sclDly;
  assign bus.start_det = 1'b0;
  assign bus.stop_det  = 1'b0;
  assign bus.bus_busy  = 1'b0;
`endif

endmodule
